// File: rtl/cla_seq_pkg.sv
// Shared definitions for the multi-word CLA add sequencer.
//   WORD_W    : width of one adder slice
//   MAX_WORDS : largest supported slice count
//   seq_state_e : sequencer control states
package cla_seq_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned MAX_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/cla16_word_sequencer.sv
// Multi-word add controller driving an external 16-bit handshaked CLA adder.
// Latches an N_WORDS*16-bit operand pair plus carry on start. It then issues
// one slice at a time, least significant word first, and chains the carry
// between slices. The full-width sum is assembled as the slices complete.
//
// Ports:
//   clk, reset         : rising-edge clock, async active-high reset
//   start              : request, sampled only while idle
//   a, b, c_in         : operands and carry-in, latched on accepted start
//   busy, done         : in-progress flag, one-cycle completion pulse
//   sum, c_out, error  : result (valid with done), error = timeout abort
//   add_en/a/b/cin     : slice request to the adder
//   add_result/cout/ready : adder response
//
// Build option: define CLA_SEQ_TIMEOUT_EN to abort a slice when the adder
// has not answered within TIMEOUT_CYCLES cycles. When it is undefined, no
// counter is built and error stays 0.
module cla16_word_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned N_WORDS        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WORD_W*N_WORDS-1:0]   a,
  input  logic [WORD_W*N_WORDS-1:0]   b,
  input  logic                        c_in,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_W*N_WORDS-1:0]   sum,
  output logic                        c_out,
  output logic                        error,
  output logic                        add_en,
  output logic [WORD_W-1:0]           add_a,
  output logic [WORD_W-1:0]           add_b,
  output logic                        add_cin,
  input  logic [WORD_W-1:0]           add_result,
  input  logic                        add_cout,
  input  logic                        add_ready
);

  localparam int unsigned W     = WORD_W * N_WORDS;
  localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam bit CFG_OK = (N_WORDS >= 1) && (N_WORDS <= MAX_WORDS) &&
                          (TIMEOUT_CYCLES >= 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("cla16_word_sequencer: N_WORDS must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              c_out_q, c_out_d;

`ifdef CLA_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              error_q, error_d;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      c_out_q   <= 1'b0;
`ifdef CLA_SEQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      c_out_q   <= c_out_d;
`ifdef CLA_SEQ_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      error_q   <= error_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    c_out_d   = c_out_q;
`ifdef CLA_SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    error_d   = error_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          sum_d   = '0;
          c_out_d = 1'b0;
`ifdef CLA_SEQ_TIMEOUT_EN
          tmo_cnt_d = '0;
          error_d   = 1'b0;
`endif
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (add_ready) begin
          sum_d[idx_q*WORD_W +: WORD_W] = add_result;
          carry_d = add_cout;
          state_d = GAP;
        end
`ifdef CLA_SEQ_TIMEOUT_EN
        // The counter value is the number of ISSUE cycles already spent.
        // Aborting on the last one leaves exactly TIMEOUT_CYCLES cycles in ISSUE.
        else if (tmo_cnt_q == TMO_LAST) begin
          error_d = 1'b1;
          c_out_d = 1'b0;
          state_d = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end

      // Holding here while ready is still high prevents a stale ready from
      // completing the next slice before the adder has seen en low.
      GAP: begin
        if (!add_ready) begin
          if (idx_q == LAST_IDX) begin
            c_out_d = carry_q;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
`ifdef CLA_SEQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
            state_d = ISSUE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    sum     = sum_q;
    c_out   = c_out_q;
    add_en  = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == ISSUE) begin
      add_en  = 1'b1;
      add_a   = a_q[idx_q*WORD_W +: WORD_W];
      add_b   = b_q[idx_q*WORD_W +: WORD_W];
      add_cin = carry_q;
    end
`ifdef CLA_SEQ_TIMEOUT_EN
    error = error_q;
`else
    error = 1'b0;
`endif
  end

endmodule

// File: tb/tb_cla16_word_sequencer.sv
// Directed bench for cla16_word_sequencer with N_WORDS=2. A behavioural adder
// raises ready a programmable number of cycles after en rises. In sticky mode
// ready also stays high for one extra cycle after en falls.
module tb_cla16_word_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        c_out;
  logic        error;
  logic        add_en;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_result;
  logic        add_cout;
  logic        add_ready;

  int checks = 0;
  int errors = 0;

  cla16_word_sequencer #(
    .N_WORDS       (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .c_in       (c_in),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .c_out      (c_out),
    .error      (error),
    .add_en     (add_en),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_result (add_result),
    .add_cout   (add_cout),
    .add_ready  (add_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder
  int   lat    = 3;
  bit   sticky = 1'b0;
  int   en_cnt;
  logic tail_q;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      en_cnt <= 0;
      tail_q <= 1'b0;
    end else begin
      en_cnt <= add_en ? en_cnt + 1 : 0;
      tail_q <= sticky && add_en && add_ready;
    end
  end

  assign add_ready = (add_en && (en_cnt >= lat - 1)) || tail_q;
  assign {add_cout, add_result} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Results captured by run_op
  int          done_lat;
  int          n_done;
  int          n_slices;
  int          min_gap;
  logic        cin_log [4];
  logic [31:0] r_sum;
  logic        r_cout;
  logic        r_err;
  logic        r_en;
  logic        r_busy_after;

  // Starts one operation. The run then stays under observation until 4
  // samples after done or until the cycle budget runs out. When inject_at > 0,
  // a second start with operands ra/rb is driven at that sample.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                        input int inject_at, input logic [31:0] ra, input logic [31:0] rb);
    int   edges;
    int   gap_run;
    logic prev_en;
    a = oa; b = ob; c_in = oc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1; n_done = 0; n_slices = 0; min_gap = 1000; gap_run = 0;
    prev_en = 1'b0; done_lat = -1; r_busy_after = 1'bx;
    for (int k = 0; k < 4; k++) cin_log[k] = 1'bx;
    for (int i = 0; i < 200; i++) begin
      if (add_en && !prev_en) begin
        if (n_slices > 0 && gap_run < min_gap) min_gap = gap_run;
        if (n_slices < 4) cin_log[n_slices] = add_cin;
        n_slices++;
        gap_run = 0;
      end
      if (!add_en && busy && !done) gap_run++;
      if (done) begin
        n_done++;
        if (done_lat < 0) begin
          done_lat = edges;
          r_sum = sum; r_cout = c_out; r_err = error; r_en = add_en;
        end
      end
      if (done_lat >= 0 && edges == done_lat + 1) r_busy_after = busy;
      if (inject_at > 0 && edges == inject_at) begin
        a = ra; b = rb; c_in = ~oc; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      prev_en = add_en;
      if (done_lat >= 0 && edges >= done_lat + 4) break;
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
  endtask

  initial begin
    int nd;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", c_out, 1'b0);
    chk("rst_err", error, 1'b0);
    chk("rst_en", add_en, 1'b0);
    chk("rst_adda", add_a, 16'h0);
    chk("rst_addb", add_b, 16'h0);
    chk("rst_cin", add_cin, 1'b0);
    #9 reset = 1'b0;
    @(posedge clk); #1;

    // 7F + 7F with a 3-cycle adder: done in the 10th cycle counting the start cycle
    lat = 3; sticky = 1'b0;
    run_op(32'h0000_007F, 32'h0000_007F, 1'b0, 0, '0, '0);
    chk("t1_lat", done_lat, 9);
    chk("t1_sum", r_sum, 32'h0000_00FE);
    chk("t1_cout", r_cout, 1'b0);
    chk("t1_err", r_err, 1'b0);
    chk("t1_ndone", n_done, 1);
    chk("t1_busy_after", r_busy_after, 1'b0);
    chk("t1_sum_held", sum, 32'h0000_00FE);

    // Carry from slice 0 into slice 1
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, '0, '0);
    chk("t2_cin0", cin_log[0], 1'b0);
    chk("t2_cin1", cin_log[1], 1'b1);
    chk("t2_sum", r_sum, 32'h0001_0000);
    chk("t2_cout", r_cout, 1'b0);

    // Full carry ripple with c_in, en low between slices
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, '0, '0);
    chk("t3_sum", r_sum, 32'h0000_0000);
    chk("t3_cout", r_cout, 1'b1);
    chk("t3_gap", min_gap >= 1, 1'b1);
    chk("t3_slices", n_slices, 2);

    // Second start during ISSUE is ignored
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 2, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("t4_sum", r_sum, 32'h2345_6789);
    chk("t4_cout", r_cout, 1'b0);
    chk("t4_ndone", n_done, 1);

    // Ready already high on ISSUE entry, and still high one cycle into GAP
    lat = 1; sticky = 1'b1;
    run_op(32'h0001_8000, 32'h0002_8000, 1'b0, 0, '0, '0);
    chk("t5_lat", done_lat, 7);
    chk("t5_gap", min_gap, 2);
    chk("t5_sum", r_sum, 32'h0004_0000);
    chk("t5_cout", r_cout, 1'b0);
    chk("t5_ndone", n_done, 1);

    // Async reset during ISSUE of slice 1
    lat = 3; sticky = 1'b0;
    a = 32'h0000_FFFF; b = 32'h0000_0001; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      if (add_en && dut.idx_q == 1'b1) break;
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("t6_reached_slice1", add_en && add_cin, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_sum", sum, 32'h0);
    chk("t6_en", add_en, 1'b0);
    chk("t6_cin", add_cin, 1'b0);
    chk("t6_adda", add_a, 16'h0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("t6_no_done", nd, 0);
    run_op(32'h8000_8000, 32'h8000_8000, 1'b1, 0, '0, '0);
    chk("t6_post_sum", r_sum, 32'h0001_0001);
    chk("t6_post_cout", r_cout, 1'b1);
    chk("t6_post_lat", done_lat, 9);

`ifdef CLA_SEQ_TIMEOUT_EN
    // Adder never answers: abort 8 cycles after ISSUE entry
    lat = 100000;
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0, '0, '0);
    chk("tmo_lat", done_lat, 9);
    chk("tmo_err", r_err, 1'b1);
    chk("tmo_en", r_en, 1'b0);
    chk("tmo_sum", r_sum, 32'h0);
    chk("tmo_cout", r_cout, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
